vx_axi_ram_slave: RTL and testbench

AXI4 slave responder backed by an on-chip dual-port RAM. It answers the Vortex AXI4 memory master (m_axi_mem_*) in the Xilinx test project, so the GPU top runs without external DDR. Read and write channels are served by independent FSMs, with one outstanding transaction per direction. It supports FIXED and INCR bursts up to 256 beats.

---
 rtl/vx_axi_ram_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_vx_axi_ram_slave.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_axi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : vx_axi_ram_slave
// Purpose  : AXI4 slave backed by on-chip dual-port RAM; independent read and
//            write FSMs, one outstanding transaction each, FIXED/INCR bursts.
//            Optional random handshake stalls: define VX_AXI_RAM_RAND_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vx_axi_ram_slave #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 32,
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,
    input  logic [1:0]              s_axi_arburst,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    busy
);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         OFF         = $clog2(STRB_W);
    localparam int         DEPTH       = 1 << MEM_WORDS_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DLY, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DLY, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    wstate_t                   wstate;
    rstate_t                   rstate;
    logic [MEM_WORDS_LOG2-1:0] widx, ridx;
    logic [7:0]                wlen, wcnt, rlen, rcnt;
    logic [1:0]                wburst, rburst;
    logic                      werr;
    logic                      awready_q, wready_q, arready_q;
    logic                      hs_stall, resp_delay;
    logic                      w_fire, w_last_beat, w_proto_err;
    logic                      unused_addr_bits;

`ifdef VX_AXI_RAM_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign hs_stall   = (lfsr[1:0] == 2'b00);
    assign resp_delay = (lfsr[3:2] == 2'b00);
`else
    assign hs_stall   = 1'b0;
    assign resp_delay = 1'b0;
`endif

    // Only the word-index slice of each address is meaningful; the rest aliases.
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = awready_q & ~hs_stall;
    assign s_axi_wready  = wready_q  & ~hs_stall;
    assign s_axi_arready = arready_q & ~hs_stall;
    assign busy          = (wstate != W_IDLE) | (rstate != R_IDLE);

    assign w_fire      = (wstate == W_DATA) && s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (wcnt == wlen);
    assign w_proto_err = (s_axi_wlast != w_last_beat);

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate       <= W_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_bid    <= '0;
            widx         <= '0;
            wlen         <= 8'd0;
            wcnt         <= 8'd0;
            wburst       <= BURST_FIXED;
            werr         <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        s_axi_bid <= s_axi_awid;
                        widx      <= s_axi_awaddr[OFF +: MEM_WORDS_LOG2];
                        wlen      <= s_axi_awlen;
                        wcnt      <= 8'd0;
                        wburst    <= s_axi_awburst;
                        werr      <= 1'b0;
                        wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        wcnt <= wcnt + 8'd1;
                        if (wburst != BURST_FIXED) widx <= widx + 1'b1;
                        werr <= werr | w_proto_err;
                        if (w_last_beat) begin
                            wready_q    <= 1'b0;
                            // WRAP and reserved bursts run as INCR but are flagged.
                            s_axi_bresp <= (werr || w_proto_err || wburst[1]) ? RESP_SLVERR : RESP_OKAY;
                            if (resp_delay) begin
                                wstate <= W_DLY;
                            end else begin
                                s_axi_bvalid <= 1'b1;
                                wstate       <= W_RESP;
                            end
                        end
                    end
                end
                W_DLY: begin
                    s_axi_bvalid <= 1'b1;
                    wstate       <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        awready_q    <= 1'b1;
                        wstate       <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Reset only gates the write strobe; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_fire && !reset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstate == R_FETCH) s_axi_rdata <= mem[ridx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate       <= R_IDLE;
            arready_q    <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rlast  <= 1'b0;
            s_axi_rid    <= '0;
            ridx         <= '0;
            rlen         <= 8'd0;
            rcnt         <= 8'd0;
            rburst       <= BURST_FIXED;
        end else begin
            case (rstate)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        arready_q <= 1'b0;
                        s_axi_rid <= s_axi_arid;
                        ridx      <= s_axi_araddr[OFF +: MEM_WORDS_LOG2];
                        rlen      <= s_axi_arlen;
                        rcnt      <= 8'd0;
                        rburst    <= s_axi_arburst;
                        rstate    <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    s_axi_rlast <= (rcnt == rlen);
                    s_axi_rresp <= rburst[1] ? RESP_SLVERR : RESP_OKAY;
                    if (resp_delay) begin
                        rstate <= R_DLY;
                    end else begin
                        s_axi_rvalid <= 1'b1;
                        rstate       <= R_DATA;
                    end
                end
                R_DLY: begin
                    s_axi_rvalid <= 1'b1;
                    rstate       <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        s_axi_rlast  <= 1'b0;
                        if (s_axi_rlast) begin
                            arready_q <= 1'b1;
                            rstate    <= R_IDLE;
                        end else begin
                            rcnt <= rcnt + 8'd1;
                            if (rburst != BURST_FIXED) ridx <= ridx + 1'b1;
                            rstate <= R_FETCH;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vx_axi_ram_slave.sv
`default_nettype none
// Scoreboard bench for vx_axi_ram_slave: expected B/R responses are queued as
// stimulus is issued and popped as the DUT returns them.
module tb_vx_axi_ram_slave;
    localparam int DW  = 512;
    localparam int AW  = 32;
    localparam int IW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [7:0]    awlen, arlen;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic          arvalid, arready, rvalid, rready, rlast, busy;

    typedef struct {logic [DW-1:0] data; logic last; logic [1:0] resp; logic [IW-1:0] id;} rexp_t;
    typedef struct {logic [1:0] resp; logic [IW-1:0] id;} bexp_t;
    rexp_t exp_r[$];
    bexp_t exp_b[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vx_axi_ram_slave dut (
        .clk(clk), .reset(reset),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rid(rid), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .busy(busy)
    );

    function automatic logic [DW-1:0] word(input int v);
        word = '0;
        word[31:0] = v;
    endfunction

    // All channel tasks start and end on a falling edge.
    task automatic send_aw(input logic [AW-1:0] a, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        awaddr = a; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        while (!awready && t < TMO) begin @(negedge clk); t++; end
        vectors++;
        if (awready !== 1'b1) begin
            miscompares++;
            $display("FAIL aw_handshake: awready=%b required=1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        int t = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && t < TMO) begin @(negedge clk); t++; end
        vectors++;
        if (wready !== 1'b1) begin
            miscompares++;
            $display("FAIL w_handshake: wready=%b required=1", wready);
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        araddr = a; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        while (!arready && t < TMO) begin @(negedge clk); t++; end
        vectors++;
        if (arready !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_handshake: arready=%b required=1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic recv_b();
        int t = 0;
        bexp_t e;
        bready = 1'b1;
        while (!bvalid && t < TMO) begin @(negedge clk); t++; end
        e = exp_b.pop_front();
        vectors++;
        if (bvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL b_timeout: bvalid=%b required=1", bvalid);
        end else if (bresp !== e.resp || bid !== e.id) begin
            miscompares++;
            $display("FAIL b_resp: bresp=%b bid=%h required bresp=%b bid=%h", bresp, bid, e.resp, e.id);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic recv_r(input int stall_beat);
        int t, beat;
        bit done;
        rexp_t e;
        logic [DW-1:0] held;
        beat = 0; done = 0;
        while (!done) begin
            rready = (beat != stall_beat);
            t = 0;
            while (!rvalid && t < TMO) begin @(negedge clk); t++; end
            if (rvalid !== 1'b1) begin
                vectors++; miscompares++;
                $display("FAIL r_timeout: rvalid=%b required=1 beat=%0d", rvalid, beat);
                done = 1;
            end else if (exp_r.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL r_extra_beat: rvalid=1 required no beat %0d", beat);
                done = 1;
            end else begin
                if (beat == stall_beat) begin
                    held = rdata;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        vectors++;
                        if (rvalid !== 1'b1 || rdata !== held) begin
                            miscompares++;
                            $display("FAIL r_stall_hold: rvalid=%b rdata[31:0]=%h required 1 %h",
                                     rvalid, rdata[31:0], held[31:0]);
                        end
                    end
                    rready = 1'b1;
                end
                e = exp_r.pop_front();
                vectors++;
                if (rdata !== e.data || rlast !== e.last || rresp !== e.resp || rid !== e.id) begin
                    miscompares++;
                    $display("FAIL r_beat%0d: data[31:0]=%h last=%b resp=%b id=%h required %h %b %b %h",
                             beat, rdata[31:0], rlast, rresp, rid, e.data[31:0], e.last, e.resp, e.id);
                end
                if (rlast === 1'b1 || exp_r.size() == 0) done = 1;
                @(negedge clk);
                beat++;
            end
        end
        rready = 1'b0;
        vectors++;
        if (exp_r.size() != 0) begin
            miscompares++;
            $display("FAIL r_missing: beats_left=%0d required 0", exp_r.size());
            exp_r.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, busy, bresp, rresp} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: aw=%b ar=%b w=%b bv=%b rv=%b rl=%b busy=%b br=%b rr=%b required all 0",
                     awready, arready, wready, bvalid, rvalid, rlast, busy, bresp, rresp);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (awready !== 1'b1 || arready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: awready=%b arready=%b busy=%b required 1 1 0", awready, arready, busy);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] a5 = {SW{8'hA5}};
        send_aw(32'h40, 32'h11, 8'd0, 2'b01);
        send_w(a5, '1, 1'b1);
        exp_b.push_back('{2'b00, 32'h11});
        recv_b();
        exp_r.push_back('{a5, 1'b1, 2'b00, 32'h22});
        send_ar(32'h40, 32'h22, 8'd0, 2'b01);
        recv_r(-1);
        exp_r.push_back('{a5, 1'b1, 2'b00, 32'h23});
        send_ar(32'h45, 32'h23, 8'd0, 2'b01);   // unaligned start lands on the same word
        recv_r(-1);
    endtask

    task automatic test_incr();
        send_aw(32'h1000, 32'h33, 8'd3, 2'b01);
        for (int b = 0; b < 4; b++) send_w(word(b + 1), '1, b == 3);
        exp_b.push_back('{2'b00, 32'h33});
        recv_b();
        for (int b = 0; b < 4; b++) exp_r.push_back('{word(b + 1), b == 3, 2'b00, 32'h34});
        send_ar(32'h1000, 32'h34, 8'd3, 2'b01);
        recv_r(-1);
    endtask

    task automatic test_fixed();
        send_aw(32'h80, 32'h44, 8'd1, 2'b00);
        send_w(word(32'h111), '1, 1'b0);
        send_w(word(32'h222), '1, 1'b1);
        exp_b.push_back('{2'b00, 32'h44});
        recv_b();
        exp_r.push_back('{word(32'h222), 1'b0, 2'b00, 32'h45});
        exp_r.push_back('{word(32'h222), 1'b1, 2'b00, 32'h45});
        send_ar(32'h80, 32'h45, 8'd1, 2'b00);
        recv_r(-1);
    endtask

    task automatic test_strobe();
        send_aw(32'h200, 32'h55, 8'd0, 2'b01);
        send_w({SW{8'hFF}}, '1, 1'b1);
        exp_b.push_back('{2'b00, 32'h55});
        recv_b();
        send_aw(32'h200, 32'h56, 8'd0, 2'b01);
        send_w('0, 64'h1, 1'b1);
        exp_b.push_back('{2'b00, 32'h56});
        recv_b();
        exp_r.push_back('{{{(SW-1){8'hFF}}, 8'h00}, 1'b1, 2'b00, 32'h57});
        send_ar(32'h200, 32'h57, 8'd0, 2'b01);
        recv_r(-1);
    endtask

    task automatic test_protocol_err();
        send_aw(32'h280, 32'h66, 8'd1, 2'b01);
        send_w(word(7), '1, 1'b1);
        send_w(word(8), '1, 1'b0);
        exp_b.push_back('{2'b10, 32'h66});
        recv_b();
        send_aw(32'h300, 32'h67, 8'd1, 2'b10);
        send_w(word(9), '1, 1'b0);
        send_w(word(10), '1, 1'b1);
        exp_b.push_back('{2'b10, 32'h67});
        recv_b();
        exp_r.push_back('{word(9), 1'b0, 2'b10, 32'h68});
        exp_r.push_back('{word(10), 1'b1, 2'b10, 32'h68});
        send_ar(32'h300, 32'h68, 8'd1, 2'b10);
        recv_r(-1);
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < 4; b++) exp_r.push_back('{word(b + 1), b == 3, 2'b00, 32'h77});
        send_ar(32'h1000, 32'h77, 8'd3, 2'b01);
        recv_r(2);
    endtask

    task automatic test_wrap_around();
        send_aw(32'h3FFC0, 32'h88, 8'd1, 2'b01);
        send_w(word(32'hAAA1), '1, 1'b0);
        send_w(word(32'hAAA2), '1, 1'b1);
        exp_b.push_back('{2'b00, 32'h88});
        recv_b();
        exp_r.push_back('{word(32'hAAA1), 1'b0, 2'b00, 32'h89});
        exp_r.push_back('{word(32'hAAA2), 1'b1, 2'b00, 32'h89});
        send_ar(32'h3FFC0, 32'h89, 8'd1, 2'b01);
        recv_r(-1);
        exp_r.push_back('{word(32'hAAA2), 1'b1, 2'b00, 32'h8A});
        send_ar(32'h40000, 32'h8A, 8'd0, 2'b01);   // upper bits alias onto word 0
        recv_r(-1);
    endtask

    task automatic test_reset_mid_burst();
        int seen_b = 0;
        send_aw(32'h2000, 32'h99, 8'd3, 2'b01);
        send_w(word(32'hB1), '1, 1'b0);
        send_w(word(32'hB2), '1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        vectors++;
        if (awready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: awready=%b busy=%b required 1 0", awready, busy);
        end
        for (int k = 0; k < 6; k++) begin
            if (bvalid === 1'b1) seen_b++;
            @(negedge clk);
        end
        bready = 1'b0;
        vectors++;
        if (seen_b != 0) begin
            miscompares++;
            $display("FAIL mid_reset_bvalid: bvalid_cycles=%0d required 0", seen_b);
        end
        exp_r.push_back('{word(32'hB1), 1'b0, 2'b00, 32'h9A});
        exp_r.push_back('{word(32'hB2), 1'b1, 2'b00, 32'h9A});
        send_ar(32'h2000, 32'h9A, 8'd1, 2'b01);
        recv_r(-1);
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 0; awaddr = '0; awid = '0; awlen = '0; awburst = '0;
        wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
        arvalid = 0; araddr = '0; arid = '0; arlen = '0; arburst = '0; rready = 0;
        test_reset();
        test_single();
        test_incr();
        test_fixed();
        test_strobe();
        test_protocol_err();
        test_backpressure();
        test_wrap_around();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
